// File: rtl/ghost_pkg.sv
// Shared encodings for the ghost tracker: directions, wall-bit layout and
// the tracker FSM state type.
package ghost_pkg;

  localparam logic [2:0] DIR_NONE  = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b100;
  localparam logic [2:0] DIR_RIGHT = 3'b101;
  localparam logic [2:0] DIR_DOWN  = 3'b110;
  localparam logic [2:0] DIR_LEFT  = 3'b111;

  localparam logic [1:0] WALL_UP    = 2'd0;
  localparam logic [1:0] WALL_RIGHT = 2'd1;
  localparam logic [1:0] WALL_DOWN  = 2'd2;
  localparam logic [1:0] WALL_LEFT  = 2'd3;

  localparam int TILE_SHIFT = 4;

  // Scan states are encoded so that state[1:0] is the wall bit being scanned.
  typedef enum logic [2:0] {
    SCAN_UP    = 3'd0,
    SCAN_RIGHT = 3'd1,
    SCAN_DOWN  = 3'd2,
    SCAN_LEFT  = 3'd3,
    COMMIT     = 3'd4,
    IDLE       = 3'd5
  } tracker_state_e;

  function automatic tracker_state_e next_scan(input tracker_state_e s);
    case (s)
      SCAN_UP:    next_scan = SCAN_RIGHT;
      SCAN_RIGHT: next_scan = SCAN_DOWN;
      SCAN_DOWN:  next_scan = SCAN_LEFT;
      default:    next_scan = COMMIT;
    endcase
  endfunction

endpackage

// File: rtl/maze_neighbour_addr.sv
// Neighbour tile address for one of the four directions. Columns wrap
// around the maze width; rows do not and report out-of-bounds instead.
module maze_neighbour_addr
  import ghost_pkg::*;
(
  input  logic [5:0] tile_x,
  input  logic [5:0] tile_y,
  input  logic [1:0] nb_idx,
  input  logic [5:0] tiles_x,
  input  logic [5:0] tiles_y,
  output logic [5:0] nb_x,
  output logic [5:0] nb_y,
  output logic       oob
);

  always_comb begin
    nb_x = tile_x;
    nb_y = tile_y;
    oob  = 1'b0;
    case (nb_idx)
      WALL_UP: begin
        oob  = (tile_y == 6'd0);
        nb_y = tile_y - 6'd1;
      end
      WALL_RIGHT: nb_x = (tile_x == tiles_x - 6'd1) ? 6'd0 : tile_x + 6'd1;
      WALL_DOWN: begin
        oob  = (tile_y == tiles_y - 6'd1);
        nb_y = tile_y + 6'd1;
      end
      default: nb_x = (tile_x == 6'd0) ? tiles_x - 6'd1 : tile_x - 6'd1;
    endcase
  end

endmodule

// File: rtl/ghost_position_tracker.sv
// Integrates ghost pixel position on move ticks and rescans the four
// neighbouring walls through the maze map each time the ghost lands on a tile.
module ghost_position_tracker
  import ghost_pkg::*;
#(
  parameter logic [9:0] START_X      = 10'd224,
  parameter logic [9:0] START_Y      = 10'd256,
  parameter int         MAZE_TILES_X = 28,
  parameter int         MAZE_TILES_Y = 31
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           move_tick,
  input  logic [2:0]     direction,
  output logic [9:0]     pos_x,
  output logic [9:0]     pos_y,
  output logic [3:0]     adjacent_walls,
  output logic           walls_valid,
  output logic           map_req,
  output logic [5:0]     map_tile_x,
  output logic [5:0]     map_tile_y,
  input  logic           map_ack,
  input  logic           map_wall,
  output tracker_state_e dbg_state
);

  localparam logic [9:0] MAX_X   = 10'(MAZE_TILES_X * 16 - 1);
  localparam logic [9:0] MAX_Y   = 10'(MAZE_TILES_Y * 16 - 1);
  localparam logic [5:0] TILES_X = 6'(MAZE_TILES_X);
  localparam logic [5:0] TILES_Y = 6'(MAZE_TILES_Y);

  tracker_state_e state_q, state_d;
  logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [3:0] walls_q, walls_d, shadow_q, shadow_d;
  logic       walls_valid_q, walls_valid_d;
  logic       map_req_q, map_req_d;
  logic [5:0] tile_x_q, tile_x_d, tile_y_q, tile_y_d;
  logic       pend_q, pend_d;
  logic [9:0] step_x, step_y;
  logic [5:0] nb_x, nb_y;
  logic       nb_oob;

  maze_neighbour_addr u_nb (
    .tile_x  (pos_x_q[9:TILE_SHIFT]),
    .tile_y  (pos_y_q[9:TILE_SHIFT]),
    .nb_idx  (state_q[1:0]),
    .tiles_x (TILES_X),
    .tiles_y (TILES_Y),
    .nb_x    (nb_x),
    .nb_y    (nb_y),
    .oob     (nb_oob)
  );

  always_comb begin
    state_d       = state_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    walls_d       = walls_q;
    shadow_d      = shadow_q;
    walls_valid_d = walls_valid_q;
    map_req_d     = map_req_q;
    tile_x_d      = tile_x_q;
    tile_y_d      = tile_y_q;
    pend_d        = pend_q;
    step_x        = pos_x_q;
    step_y        = pos_y_q;
    case (state_q)
      SCAN_UP, SCAN_RIGHT, SCAN_DOWN, SCAN_LEFT: begin
        if (move_tick) pend_d = 1'b1;
        // A fresh request is raised one cycle after entering each scan state.
        if (!map_req_q) begin
          if (nb_oob) begin
            shadow_d[state_q[1:0]] = 1'b1;
            state_d = next_scan(state_q);
          end else begin
            map_req_d = 1'b1;
            tile_x_d  = nb_x;
            tile_y_d  = nb_y;
          end
        end else if (map_ack) begin
          shadow_d[state_q[1:0]] = map_wall;
          map_req_d = 1'b0;
          state_d   = next_scan(state_q);
        end
      end
      COMMIT: begin
        if (move_tick) pend_d = 1'b1;
        walls_d       = shadow_q;
        walls_valid_d = 1'b1;
        map_req_d     = 1'b0;
        state_d       = IDLE;
      end
      IDLE: begin
        pend_d = 1'b0;
        if ((move_tick || pend_q) && direction[2]) begin
          case (direction)
            DIR_UP:    step_y = (pos_y_q == 10'd0) ? 10'd0 : pos_y_q - 10'd1;
            DIR_DOWN:  step_y = (pos_y_q == MAX_Y) ? MAX_Y : pos_y_q + 10'd1;
            DIR_RIGHT: step_x = (pos_x_q == MAX_X) ? 10'd0 : pos_x_q + 10'd1;
            default:   step_x = (pos_x_q == 10'd0) ? MAX_X : pos_x_q - 10'd1;
          endcase
          pos_x_d = step_x;
          pos_y_d = step_y;
          if (step_x[3:0] == 4'd0 && step_y[3:0] == 4'd0) begin
            state_d       = SCAN_UP;
            walls_valid_d = 1'b0;
            walls_d       = 4'b1111;
          end
        end
      end
      default: state_d = SCAN_UP;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= SCAN_UP;
      pos_x_q       <= START_X;
      pos_y_q       <= START_Y;
      walls_q       <= 4'b1111;
      shadow_q      <= 4'b1111;
      walls_valid_q <= 1'b0;
      map_req_q     <= 1'b0;
      tile_x_q      <= 6'd0;
      tile_y_q      <= 6'd0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      walls_q       <= walls_d;
      shadow_q      <= shadow_d;
      walls_valid_q <= walls_valid_d;
      map_req_q     <= map_req_d;
      tile_x_q      <= tile_x_d;
      tile_y_q      <= tile_y_d;
      pend_q        <= pend_d;
    end
  end

  assign pos_x          = pos_x_q;
  assign pos_y          = pos_y_q;
  assign adjacent_walls = walls_q;
  assign walls_valid    = walls_valid_q;
  assign map_req        = map_req_q;
  assign map_tile_x     = tile_x_q;
  assign map_tile_y     = tile_y_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ghost_position_tracker.sv
// Bench for ghost_position_tracker: table of movement vectors, a maze-map
// responder that scoreboards lookup addresses, and hand-written corner cases.
module tb_ghost_position_tracker;
  import ghost_pkg::*;

  logic           Clk = 1'b0;
  logic           Reset, move_tick, map_ack, map_wall;
  logic [2:0]     direction;
  logic [9:0]     pos_x, pos_y;
  logic [3:0]     adjacent_walls;
  logic           walls_valid, map_req;
  logic [5:0]     map_tile_x, map_tile_y;
  tracker_state_e dbg_state;

  int tests = 0;
  int fails = 0;
  logic [11:0] exp_q[$];
  int   ack_delay = 0;
  int   ack_count = 0;
  int   wait_cnt  = 0;
  bit   req_seen  = 0;
  bit   spurious  = 0;
  logic [11:0] held_tile, exp_tile;
  int   m_x = 224;
  int   m_y = 256;
  logic [3:0] m_walls = 4'b1111;

  ghost_position_tracker dut (
    .Clk(Clk), .Reset(Reset), .move_tick(move_tick), .direction(direction),
    .pos_x(pos_x), .pos_y(pos_y), .adjacent_walls(adjacent_walls),
    .walls_valid(walls_valid), .map_req(map_req), .map_tile_x(map_tile_x),
    .map_tile_y(map_tile_y), .map_ack(map_ack), .map_wall(map_wall),
    .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Map contents: every even column is a wall.
  function automatic logic wall_at(input int tx);
    return (tx % 2) == 0;
  endfunction

  task automatic push_scan(input int x, input int y);
    int tx, ty, nx;
    logic [3:0] w;
    tx = x / 16;
    ty = y / 16;
    if (ty == 0) w[0] = 1'b1;
    else begin exp_q.push_back({6'(tx), 6'(ty - 1)}); w[0] = wall_at(tx); end
    nx = (tx + 1) % 28;
    exp_q.push_back({6'(nx), 6'(ty)}); w[1] = wall_at(nx);
    if (ty == 30) w[2] = 1'b1;
    else begin exp_q.push_back({6'(tx), 6'(ty + 1)}); w[2] = wall_at(tx); end
    nx = (tx + 27) % 28;
    exp_q.push_back({6'(nx), 6'(ty)}); w[3] = wall_at(nx);
    m_walls = w;
  endtask

  // Maze-map responder: acks each request after ack_delay cycles.
  initial begin
    map_ack = 1'b0;
    map_wall = 1'b0;
    forever begin
      @(posedge Clk); #1;
      if (Reset) begin
        map_ack = 1'b0;
        req_seen = 1'b0;
      end else if (map_ack) begin
        map_ack = 1'b0;
        req_seen = 1'b0;
      end else if (map_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          wait_cnt = ack_delay;
          held_tile = {map_tile_x, map_tile_y};
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL lookup_unexpected: tile (%0d,%0d), required no request", map_tile_x, map_tile_y);
          end else begin
            exp_tile = exp_q.pop_front();
            check("lookup_tile", 32'({map_tile_x, map_tile_y}), 32'(exp_tile));
          end
        end else begin
          check("lookup_stable", 32'({map_tile_x, map_tile_y}), 32'(held_tile));
        end
        if (wait_cnt == 0) begin
          map_ack = 1'b1;
          map_wall = ~map_tile_x[0];
          ack_count++;
        end else wait_cnt--;
      end else if (spurious) begin
        map_ack = 1'b1;
        map_wall = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (walls_valid !== 1'b1 && n < 400) begin @(negedge Clk); n++; end
    if (walls_valid !== 1'b1) begin
      tests++; fails++;
      $display("FAIL idle_timeout: walls_valid=%b after %0d cycles, required 1", walls_valid, n);
    end
  endtask

  task automatic do_tick(input logic [2:0] dir);
    logic exp_wv = 1'b1;
    wait_idle();
    direction = dir;
    move_tick = 1'b1;
    if (dir[2]) begin
      case (dir)
        3'b100:  m_y = (m_y == 0) ? 0 : m_y - 1;
        3'b110:  m_y = (m_y == 495) ? 495 : m_y + 1;
        3'b101:  m_x = (m_x + 1) % 448;
        default: m_x = (m_x + 447) % 448;
      endcase
      if (m_x % 16 == 0 && m_y % 16 == 0) begin
        push_scan(m_x, m_y);
        exp_wv = 1'b0;
      end
    end
    @(negedge Clk);
    move_tick = 1'b0;
    check("walls_valid_after_tick", 32'(walls_valid), 32'(exp_wv));
  endtask

  typedef struct {
    logic [2:0] dir;
    int         n;
    int         exp_x;
    int         exp_y;
  } vec_t;

  vec_t vecs[13];
  int   base;

  initial begin
    vecs[0]  = '{3'b101, 1,   225, 256};
    vecs[1]  = '{3'b101, 15,  240, 256};
    vecs[2]  = '{3'b110, 16,  240, 272};
    vecs[3]  = '{3'b000, 3,   240, 272};
    vecs[4]  = '{3'b010, 2,   240, 272};
    vecs[5]  = '{3'b111, 16,  224, 272};
    vecs[6]  = '{3'b100, 16,  224, 256};
    vecs[7]  = '{3'b111, 224, 0,   256};
    vecs[8]  = '{3'b111, 1,   447, 256};
    vecs[9]  = '{3'b111, 15,  432, 256};
    vecs[10] = '{3'b100, 256, 432, 0};
    vecs[11] = '{3'b110, 480, 432, 480};
    vecs[12] = '{3'b101, 16,  0,   480};

    Reset = 1'b1;
    move_tick = 1'b1;
    direction = 3'b101;
    repeat (3) @(negedge Clk);
    move_tick = 1'b0;
    check("reset_pos_x", 32'(pos_x), 224);
    check("reset_pos_y", 32'(pos_y), 256);
    check("reset_walls", 32'(adjacent_walls), 32'hF);
    check("reset_walls_valid", 32'(walls_valid), 0);
    check("reset_map_req", 32'(map_req), 0);
    push_scan(224, 256);
    Reset = 1'b0;
    @(negedge Clk);
    check("first_req", 32'(map_req), 1);
    check("first_req_x", 32'(map_tile_x), 14);
    check("first_req_y", 32'(map_tile_y), 15);
    wait_idle();
    check("first_walls", 32'(adjacent_walls), 32'h5);
    check("first_req_dropped", 32'(map_req), 0);

    for (int v = 0; v < 13; v++) begin
      for (int k = 0; k < vecs[v].n; k++) do_tick(vecs[v].dir);
      wait_idle();
      check($sformatf("v%0d_pos_x", v), 32'(pos_x), vecs[v].exp_x);
      check($sformatf("v%0d_pos_y", v), 32'(pos_y), vecs[v].exp_y);
      check($sformatf("v%0d_walls", v), 32'(adjacent_walls), 32'(m_walls));
      check($sformatf("v%0d_map_req", v), 32'(map_req), 0);
    end

    // Ack while no request is outstanding must be ignored.
    spurious = 1'b1;
    repeat (2) @(negedge Clk);
    spurious = 1'b0;
    repeat (2) @(negedge Clk);
    check("spurious_walls", 32'(adjacent_walls), 32'(m_walls));
    check("spurious_valid", 32'(walls_valid), 1);
    check("spurious_pos_x", 32'(pos_x), 0);

    // Two ticks during a slow scan collapse into one deferred step.
    ack_delay = 5;
    for (int k = 0; k < 16; k++) do_tick(3'b101);
    move_tick = 1'b1;
    @(negedge Clk); move_tick = 1'b0;
    @(negedge Clk); move_tick = 1'b1;
    @(negedge Clk); move_tick = 1'b0;
    wait_idle();
    check("pend_before_step", 32'(pos_x), 16);
    check("pend_walls", 32'(adjacent_walls), 32'(m_walls));
    @(negedge Clk);
    check("pend_step", 32'(pos_x), 17);
    repeat (4) @(negedge Clk);
    check("pend_single_step", 32'(pos_x), 17);
    check("pend_no_scan", 32'(walls_valid), 1);
    m_x = 17;

    // Reset in the middle of a scan, after two acks.
    for (int k = 0; k < 15; k++) do_tick(3'b101);
    base = ack_count;
    for (int n = 0; n < 200 && ack_count < base + 2; n++) @(negedge Clk);
    check("midscan_acks", 32'(ack_count - base), 2);
    Reset = 1'b1;
    exp_q.delete();
    m_x = 224;
    m_y = 256;
    push_scan(224, 256);
    @(negedge Clk);
    check("midscan_map_req", 32'(map_req), 0);
    check("midscan_walls", 32'(adjacent_walls), 32'hF);
    check("midscan_walls_valid", 32'(walls_valid), 0);
    check("midscan_pos_x", 32'(pos_x), 224);
    check("midscan_pos_y", 32'(pos_y), 256);
    Reset = 1'b0;
    @(negedge Clk);
    check("restart_req", 32'(map_req), 1);
    check("restart_req_x", 32'(map_tile_x), 14);
    check("restart_req_y", 32'(map_tile_y), 15);
    wait_idle();
    check("restart_walls", 32'(adjacent_walls), 32'h5);
    check("lookups_outstanding", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
